// File: rtl/kv_create_cmd.sv
// CREATE command engine: parses opcode/key/value from the byte stream, issues one
// store insert, and returns a status (or TIMEOUT on a stalled frame) upstream.
module kv_create_cmd #(
    parameter int unsigned KEY_BYTES = 2,
    parameter int unsigned VAL_BYTES = 4,
    parameter logic [7:0]  OPCODE    = 8'h43,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [7:0]             in_byte,
    output logic                   in_ready,
    output logic                   st_req_valid,
    output logic [8*KEY_BYTES-1:0] st_req_key,
    output logic [8*VAL_BYTES-1:0] st_req_val,
    input  logic                   st_req_ready,
    input  logic                   st_ack_valid,
    input  logic [1:0]             st_ack_status,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_code,
    input  logic                   rsp_ready,
    output logic                   busy
);

    localparam int unsigned KW   = 8 * KEY_BYTES;
    localparam int unsigned VW   = 8 * VAL_BYTES;
    localparam int unsigned MAXB = (KEY_BYTES > VAL_BYTES) ? KEY_BYTES : VAL_BYTES;
    localparam int unsigned BW   = $clog2(MAXB + 1);
    localparam int unsigned IW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_KEY  = 3'd1;
    localparam logic [2:0] S_VAL  = 3'd2;
    localparam logic [2:0] S_REQ  = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_RESP = 3'd5;

    localparam logic [1:0] CODE_FULL    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    logic [2:0]    state, state_d;
    logic [BW-1:0] bcnt, bcnt_d;
    logic [IW-1:0] icnt, icnt_d;
    logic [KW-1:0] key_d;
    logic [VW-1:0] val_d;
    logic [1:0]    code_d;
    logic          in_ready_d, st_req_valid_d, rsp_valid_d, busy_d;

    logic          accept;
    logic [IW-1:0] icnt_inc;
    logic          timeout_hit;

    assign accept      = in_valid && in_ready;
    assign icnt_inc    = IW'(icnt + IW'(1));
    assign timeout_hit = (TIMEOUT != 0) && (icnt_inc == IW'(TIMEOUT));

    // Next-state, datapath and next-output decode
    always_comb begin
        state_d = state;
        bcnt_d  = bcnt;
        icnt_d  = icnt;
        key_d   = st_req_key;
        val_d   = st_req_val;
        code_d  = rsp_code;

        case (state)
            S_IDLE: begin
                if (accept && (in_byte == OPCODE)) begin
                    state_d = S_KEY;
                    bcnt_d  = '0;
                    icnt_d  = '0;
                    key_d   = '0;
                    val_d   = '0;
                end
            end
            S_KEY, S_VAL: begin
                if (accept) begin
                    icnt_d = '0;
                    if (state == S_KEY) begin
                        key_d = (st_req_key << 8) | KW'(in_byte);
                        if (bcnt == BW'(KEY_BYTES - 1)) begin
                            bcnt_d  = '0;
                            state_d = S_VAL;
                        end else begin
                            bcnt_d = BW'(bcnt + BW'(1));
                        end
                    end else begin
                        val_d = (st_req_val << 8) | VW'(in_byte);
                        if (bcnt == BW'(VAL_BYTES - 1)) begin
                            bcnt_d  = '0;
                            state_d = S_REQ;
                        end else begin
                            bcnt_d = BW'(bcnt + BW'(1));
                        end
                    end
                end else if (timeout_hit) begin
                    // Stalled frame: drop partial fields, report without touching the store
                    state_d = S_RESP;
                    code_d  = CODE_TIMEOUT;
                    bcnt_d  = '0;
                    icnt_d  = '0;
                    key_d   = '0;
                    val_d   = '0;
                end else if (TIMEOUT != 0) begin
                    icnt_d = icnt_inc;
                end
            end
            S_REQ: begin
                if (st_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (st_ack_valid) begin
                    code_d  = (st_ack_status == 2'd3) ? CODE_FULL : st_ack_status;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                bcnt_d  = '0;
                icnt_d  = '0;
            end
        endcase

        in_ready_d     = (state_d == S_IDLE) || (state_d == S_KEY) || (state_d == S_VAL);
        st_req_valid_d = (state_d == S_REQ);
        rsp_valid_d    = (state_d == S_RESP);
        busy_d         = (state_d != S_IDLE);
    end

    // State, counters, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bcnt         <= '0;
            icnt         <= '0;
            st_req_key   <= '0;
            st_req_val   <= '0;
            rsp_code     <= '0;
            in_ready     <= 1'b1;
            st_req_valid <= 1'b0;
            rsp_valid    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            bcnt         <= bcnt_d;
            icnt         <= icnt_d;
            st_req_key   <= key_d;
            st_req_val   <= val_d;
            rsp_code     <= code_d;
            in_ready     <= in_ready_d;
            st_req_valid <= st_req_valid_d;
            rsp_valid    <= rsp_valid_d;
            busy         <= busy_d;
        end
    end

endmodule
